arb_requester: RTL and testbench

Client-side counterpart of the request/grant arbiter: one requester FSM per channel turns queued jobs into held `req` lines, watches `grnt`, and holds ownership for a fixed burst of granted cycles before releasing. It sits between job sources (DMA engines, test stimulus) and the arbiter's `req`/`grnt` ports. It also detects grant starvation (timeout) and job-queue overflow.

---
 rtl/arb_requester.sv | 168 ++++++++++++++++
 tb/tb_arb_requester.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// Client-side requester for a req/grant arbiter: one FSM per channel turns queued
// jobs into held req lines, owns the resource for a fixed granted burst, then releases.
module arb_requester_ch #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic grnt,
  output logic req,
  output logic busy,
  output logic done,
  output logic timeout_err,
  output logic ovf_err
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic               terr_q, terr_d, ovf_q, ovf_d;
  logic               fin, abandon, dec, inc, full, work;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      wait_q  <= '0;
      beat_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign work = (pend_q != '0) || issue;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    fin     = 1'b0;
    abandon = 1'b0;
    case (state_q)
      IDLE: if (work) begin
        state_d = REQ;
        wait_d  = '0;
        beat_d  = '0;
      end
      REQ: begin
        if (grnt) begin
          if (BURST_LEN == 1) begin
            state_d = REL;
            fin     = 1'b1;
          end else begin
            state_d = OWN;
            beat_d  = BEAT_W'(1);
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = REL;
          abandon = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      OWN: begin
        if (grnt) begin
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = REL;
            fin     = 1'b1;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          // Grant lost mid-burst: the whole burst restarts on the next grant.
          state_d = REQ;
          beat_d  = '0;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = work ? REQ : IDLE;
        wait_d  = '0;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    req_d  = (state_d == REQ) || (state_d == OWN);
    busy_d = (state_d == OWN);
    done_d = fin;
  end

  // A job leaving and a job arriving on the same edge cancel out, even when full.
  always_comb begin
    dec    = fin || abandon;
    full   = (pend_q == '1);
    inc    = issue && (!full || dec);
    pend_d = pend_q;
    if (inc && !dec)      pend_d = pend_q + CNT_W'(1);
    else if (dec && !inc) pend_d = pend_q - CNT_W'(1);
    ovf_d  = ovf_q || (issue && full && !dec);
    terr_d = terr_q || abandon;
  end

  assign req         = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign ovf_err     = ovf_q;
endmodule

module arb_requester #(
  parameter int MAX_REQ   = 1,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_REQ-1:0] issue,
  input  logic [MAX_REQ-1:0] grnt,
  output logic [MAX_REQ-1:0] req,
  output logic [MAX_REQ-1:0] busy,
  output logic [MAX_REQ-1:0] done,
  output logic [MAX_REQ-1:0] timeout_err,
  output logic [MAX_REQ-1:0] ovf_err
);
  for (genvar i = 0; i < MAX_REQ; i++) begin : g_ch
    arb_requester_ch #(
      .BURST_LEN(BURST_LEN),
      .TIMEOUT  (TIMEOUT),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .issue      (issue[i]),
      .grnt       (grnt[i]),
      .req        (req[i]),
      .busy       (busy[i]),
      .done       (done[i]),
      .timeout_err(timeout_err[i]),
      .ovf_err    (ovf_err[i])
    );
  end
endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: 2 channels, BURST_LEN=4, TIMEOUT=8, CNT_W=2.
// Grant model: grnt = req & gmask (per-channel enable), plus gforce to inject stray grants.
module tb_arb_requester;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] issue = '0, gmask = '0, gforce = '0;
  logic [1:0] grnt, req, busy, done, timeout_err, ovf_err;
  logic [63:0] rh, bh, dh;
  int vec_cnt = 0;
  int err_cnt = 0;

  arb_requester #(.MAX_REQ(2), .BURST_LEN(4), .TIMEOUT(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .issue(issue), .grnt(grnt), .req(req), .busy(busy),
    .done(done), .timeout_err(timeout_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  assign grnt = (req & gmask) | gforce;

  task automatic do_reset();
    issue = '0; gmask = '0; gforce = '0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Entry k records outputs of channel ch after the edge that sampled ipat[k]/gpat[k].
  task automatic capture(input int ch, input int n, input logic [63:0] ipat, input logic [63:0] gpat);
    rh = '0; bh = '0; dh = '0;
    for (int k = 0; k < n; k++) begin
      issue[ch] = ipat[k];
      gmask[ch] = gpat[k];
      @(negedge clk);
      rh[k] = req[ch]; bh[k] = busy[ch]; dh[k] = done[ch];
    end
    issue[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({req, busy, done, timeout_err, ovf_err} !== 10'b0) begin
      err_cnt++; $display("FAIL reset_outputs got %b want 0", {req, busy, done, timeout_err, ovf_err});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    gforce = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec_cnt++;
      if ({req, busy, done} !== 6'b0) begin
        err_cnt++; $display("FAIL idle_grant_ignored cyc %0d got %b want 0", k, {req, busy, done});
      end
    end
    gforce = 2'b00;
    @(negedge clk);
  endtask

  // req high 4 cycles (1 REQ + 3 OWN), busy the 3 OWN cycles, done in the REL cycle.
  task automatic test_single_job();
    do_reset();
    capture(0, 12, 64'h1, '1);
    vec_cnt++; if (rh[11:0] !== 12'h00F) begin err_cnt++; $display("FAIL single_req got %h want 00f", rh[11:0]); end
    vec_cnt++; if (bh[11:0] !== 12'h00E) begin err_cnt++; $display("FAIL single_busy got %h want 00e", bh[11:0]); end
    vec_cnt++; if (dh[11:0] !== 12'h010) begin err_cnt++; $display("FAIL single_done got %h want 010", dh[11:0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    capture(0, 20, 64'h7, '1);
    vec_cnt++; if (rh[19:0] !== 20'h03DEF) begin err_cnt++; $display("FAIL b2b_req got %h want 03def", rh[19:0]); end
    vec_cnt++; if (bh[19:0] !== 20'h039CE) begin err_cnt++; $display("FAIL b2b_busy got %h want 039ce", bh[19:0]); end
    vec_cnt++; if (dh[19:0] !== 20'h04210) begin err_cnt++; $display("FAIL b2b_done got %h want 04210", dh[19:0]); end
  endtask

  task automatic test_timeout();
    do_reset();
    capture(0, 14, 64'h1, '0);
    vec_cnt++; if (rh[13:0] !== 14'h00FF) begin err_cnt++; $display("FAIL to_req got %h want 00ff", rh[13:0]); end
    vec_cnt++; if (dh[13:0] !== 14'h0) begin err_cnt++; $display("FAIL to_done got %h want 0", dh[13:0]); end
    vec_cnt++; if (timeout_err !== 2'b01) begin err_cnt++; $display("FAIL to_err got %b want 01", timeout_err); end
    repeat (5) @(negedge clk);
    vec_cnt++; if (timeout_err !== 2'b01) begin err_cnt++; $display("FAIL to_sticky got %b want 01", timeout_err); end
    do_reset();
    vec_cnt++; if (timeout_err !== 2'b00) begin err_cnt++; $display("FAIL to_clear got %b want 00", timeout_err); end
  endtask

  // Grant withheld on edges 3..5, after beat 2; burst restarts at edge 6.
  task automatic test_grant_drop();
    do_reset();
    capture(0, 12, 64'h1, 64'hFFFF_FFFF_FFFF_FFC7);
    vec_cnt++; if (rh[11:0] !== 12'h1FF) begin err_cnt++; $display("FAIL drop_req got %h want 1ff", rh[11:0]); end
    vec_cnt++; if (bh[11:0] !== 12'h1C6) begin err_cnt++; $display("FAIL drop_busy got %h want 1c6", bh[11:0]); end
    vec_cnt++; if (dh[11:0] !== 12'h200) begin err_cnt++; $display("FAIL drop_done got %h want 200", dh[11:0]); end
  endtask

  // Four issues while starved: pend saturates at 3, so exactly three bursts follow.
  task automatic test_overflow();
    do_reset();
    capture(0, 22, 64'hF, ~64'hF);
    vec_cnt++; if (dh[21:0] !== 22'h021080) begin err_cnt++; $display("FAIL ovf_done got %h want 021080", dh[21:0]); end
    vec_cnt++; if (ovf_err !== 2'b01) begin err_cnt++; $display("FAIL ovf_err got %b want 01", ovf_err); end
    vec_cnt++; if (timeout_err !== 2'b00) begin err_cnt++; $display("FAIL ovf_noto got %b want 00", timeout_err); end
  endtask

  // Issue on the completing edge: pend stays 1, so exactly one more burst.
  task automatic test_simul_issue_done();
    do_reset();
    capture(0, 16, 64'h11, '1);
    vec_cnt++; if (dh[15:0] !== 16'h0210) begin err_cnt++; $display("FAIL simul_done got %h want 0210", dh[15:0]); end
    vec_cnt++; if (rh[15:0] !== 16'h01EF) begin err_cnt++; $display("FAIL simul_req got %h want 01ef", rh[15:0]); end
  endtask

  task automatic test_rst_mid_burst();
    do_reset();
    gmask = 2'b10;
    issue = 2'b11;
    @(negedge clk);
    issue = 2'b00;
    @(negedge clk);
    vec_cnt++; if ({req, busy} !== 4'b1110) begin err_cnt++; $display("FAIL mid_pre got %b want 1110", {req, busy}); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({req, busy, done, timeout_err, ovf_err} !== 10'b0) begin
      err_cnt++; $display("FAIL mid_rst got %b want 0", {req, busy, done, timeout_err, ovf_err});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vec_cnt++; if (req !== 2'b00) begin err_cnt++; $display("FAIL mid_discard got %b want 00", req); end
    capture(1, 8, 64'h1, '1);
    vec_cnt++; if (rh[7:0] !== 8'h0F) begin err_cnt++; $display("FAIL mid_restart_req got %h want 0f", rh[7:0]); end
    vec_cnt++; if (dh[7:0] !== 8'h10) begin err_cnt++; $display("FAIL mid_restart_done got %h want 10", dh[7:0]); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_timeout();
    test_grant_drop();
    test_overflow();
    test_simul_issue_done();
    test_rst_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
